output_demux: RTL

OUTPUT_DEMUX -- requirements
Module: output_demux

---
 rtl/output_demux.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/output_demux.sv
// FFT output demultiplexer: writes butterfly beats back to the data buffer on
// intermediate stages, serialises them on the final stage. OUTPUT_DEMUX_INDEX_EN adds out_index.
module output_demux (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  stg_cnt,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:0] in0,
  input  logic [55:0] in1,
  input  logic [55:0] in2,
  input  logic [55:0] in3,
  input  logic [55:0] in4,
  input  logic [55:0] in5,
  input  logic [55:0] in6,
  input  logic [55:0] in7,
  output logic        db_wr_en,
  output logic [4:0]  db_wr_addr,
  output logic [55:0] db_out0,
  output logic [55:0] db_out1,
  output logic [55:0] db_out2,
  output logic [55:0] db_out3,
  output logic [55:0] db_out4,
  output logic [55:0] db_out5,
  output logic [55:0] db_out6,
  output logic [55:0] db_out7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [55:0] out_data,
  output logic        stage_done,
  output logic        frame_done
`ifdef OUTPUT_DEMUX_INDEX_EN
  ,
  output logic [7:0]  out_index
`endif
);

  typedef enum logic [1:0] {StWbAccept, StFinAccept, StSer} state_e;

  state_e      state_q, cur_state;
  logic [4:0]  beat_q;
  logic [2:0]  lane_q;
  logic        db_wr_en_q, stage_done_q;
  logic [4:0]  db_wr_addr_q;
  logic [55:0] lanes   [8];
  logic [55:0] db_q    [8];
  logic [55:0] hold_q  [8];
  logic        accept;
  logic        last_lane;

  assign lanes[0] = in0;
  assign lanes[1] = in1;
  assign lanes[2] = in2;
  assign lanes[3] = in3;
  assign lanes[4] = in4;
  assign lanes[5] = in5;
  assign lanes[6] = in6;
  assign lanes[7] = in7;

  // Only accept-vs-SER is stored; the accept flavour follows stg_cnt live.
  always_comb begin
    cur_state = StWbAccept;
    if (state_q == StSer) begin
      cur_state = StSer;
    end else if (stg_cnt == 3'd7) begin
      cur_state = StFinAccept;
    end
  end

  assign in_ready  = !rst && (state_q != StSer);
  assign accept    = in_valid && in_ready;
  assign last_lane = (lane_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StWbAccept;
      beat_q       <= '0;
      lane_q       <= '0;
      db_wr_en_q   <= 1'b0;
      db_wr_addr_q <= '0;
      stage_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        db_q[i]   <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      db_wr_en_q   <= 1'b0;
      stage_done_q <= 1'b0;
      unique case (cur_state)
        StWbAccept: begin
          if (accept) begin
            db_wr_en_q   <= 1'b1;
            db_wr_addr_q <= beat_q;
            stage_done_q <= (beat_q == 5'd31);
            db_q         <= lanes;
            beat_q       <= beat_q + 5'd1;
          end
        end
        StFinAccept: begin
          if (accept) begin
            hold_q  <= lanes;
            lane_q  <= '0;
            state_q <= StSer;
          end
        end
        StSer: begin
          if (out_ready) begin
            if (last_lane) begin
              state_q <= StWbAccept;
              lane_q  <= '0;
              beat_q  <= beat_q + 5'd1;
            end else begin
              lane_q <= lane_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign db_wr_en   = db_wr_en_q;
  assign db_wr_addr = db_wr_addr_q;
  assign stage_done = stage_done_q;
  assign db_out0    = db_q[0];
  assign db_out1    = db_q[1];
  assign db_out2    = db_q[2];
  assign db_out3    = db_q[3];
  assign db_out4    = db_q[4];
  assign db_out5    = db_q[5];
  assign db_out6    = db_q[6];
  assign db_out7    = db_q[7];

  assign out_valid  = (state_q == StSer);
  assign out_data   = hold_q[lane_q];
  // Last sample of the frame is flagged in the same cycle as its handshake.
  assign frame_done = out_valid && out_ready && last_lane && (beat_q == 5'd31);

`ifdef OUTPUT_DEMUX_INDEX_EN
  assign out_index = {beat_q, lane_q};
`endif

endmodule
